// File: rtl/fir_pipelined.sv
// fir_pipelined: pipelined signed FIR with loadable coefficients, registered adder tree,
// round-half-up/saturating output and valid/ready flow control on both sides.
module fir_pipelined #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int N_TAPS    = 8,
    parameter int FRAC_BITS = 15,
    parameter int OUT_W     = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [DATA_W-1:0]    in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_W-1:0]     out_data,
    output logic                        out_sat,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]    coef_wdata,
    input  logic                        clear
);
    localparam int LV    = $clog2(N_TAPS);
    localparam int ACC_W = DATA_W + COEF_W + LV;
    localparam logic signed [ACC_W:0] HALF = (ACC_W+1)'(1) << (FRAC_BITS-1);
    localparam logic signed [ACC_W:0] OMAX = (ACC_W+1)'({(OUT_W-1){1'b1}});
    localparam logic signed [ACC_W:0] OMIN = ~OMAX;

    function automatic int cnt(input int l);
        return (N_TAPS + (1 << l) - 1) >> l;
    endfunction

    logic signed [DATA_W-1:0] hist [N_TAPS];
    // one extra bit so the unity reset value 2^FRAC_BITS is exact; writes are sign-extended
    logic signed [COEF_W:0]   coef [N_TAPS];
    logic signed [ACC_W-1:0]  tree [LV+1][N_TAPS];
    logic                     v_h;
    logic [LV:0]              v;
    logic                     en;
    logic signed [ACC_W:0]    r;
    logic                     sat_hi, sat_lo;

    assign en       = !out_valid || out_ready;
    assign in_ready = en && !clear;
    assign r        = ((ACC_W+1)'(tree[LV][0]) + HALF) >>> FRAC_BITS;
    assign sat_hi   = r > OMAX;
    assign sat_lo   = r < OMIN;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int k = 0; k < N_TAPS; k++) coef[k] <= '0;
            coef[0] <= (COEF_W+1)'(1) << FRAC_BITS;
        end else if (coef_we && int'(coef_addr) < N_TAPS)
            coef[coef_addr] <= {coef_wdata[COEF_W-1], coef_wdata};

    always_ff @(posedge clk or negedge reset)
        if (!reset)
            hist <= '{default: '0};
        else if (clear)
            hist <= '{default: '0};
        else if (en && in_valid) begin
            hist[0] <= in_data;
            for (int k = 1; k < N_TAPS; k++) hist[k] <= hist[k-1];
        end

    // level 0 holds the products; level l sums pairs of level l-1, odd tail passes through
    always_ff @(posedge clk or negedge reset)
        if (!reset)
            tree <= '{default: '{default: '0}};
        else if (en) begin
            for (int i = 0; i < N_TAPS; i++) tree[0][i] <= ACC_W'(hist[i]) * ACC_W'(coef[i]);
            for (int l = 1; l <= LV; l++)
                for (int i = 0; i < N_TAPS; i++)
                    tree[l][i] <= (i >= cnt(l)) ? '0 :
                                  (2*i+1 < cnt(l-1)) ? tree[l-1][2*i] + tree[l-1][2*i+1] :
                                  tree[l-1][2*i];
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            v_h <= 1'b0;
            v   <= '0;
        end else if (clear) begin
            v_h <= 1'b0;
            v   <= '0;
        end else if (en) begin
            v_h <= in_valid;
            v   <= {v[LV-1:0], v_h};
        end

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (clear)
            out_valid <= 1'b0;
        else if (en) begin
            out_valid <= v[LV];
            out_data  <= sat_hi ? OMAX[OUT_W-1:0] : sat_lo ? OMIN[OUT_W-1:0] : r[OUT_W-1:0];
            out_sat   <= sat_hi || sat_lo;
        end
endmodule

// File: tb/tb_fir_pipelined.sv
// tb_fir_pipelined: directed vector tables plus hand sequences for stall, clear and reset.
module tb_fir_pipelined;
    logic clk = 0, reset = 0, in_valid = 0, out_ready = 0, coef_we = 0, clear = 0;
    logic signed [15:0] in_data = 0, coef_wdata = 0;
    logic [2:0] coef_addr = 0;
    logic in_ready, out_valid, out_sat, in_ready6, out_valid6, out_sat6;
    logic signed [15:0] out_data, out_data6;

    always #5 clk = ~clk;

    fir_pipelined dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .clear(clear)
    );

    fir_pipelined #(.N_TAPS(6)) dut6 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready6), .in_data(in_data),
        .out_valid(out_valid6), .out_ready(out_ready), .out_data(out_data6), .out_sat(out_sat6),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata), .clear(clear)
    );

    typedef struct { int d; int s; int c; } cap_t;
    typedef struct { int din; int dout; int sat; } vec_t;

    cap_t q[$], q6[$];
    vec_t tv[$];
    int   acc_c[$];
    int   n_cmp = 0, n_err = 0, cyc = 0, n_stall = 0, sent = 0, prev_d = 0;
    bit   bp = 0, prev_stall = 0, acc_seen = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        cap_t c;
        bit   stall;
        @(negedge clk);
        acc_seen = in_valid && in_ready;
        if (out_valid && out_ready) begin
            c.d = int'(out_data); c.s = int'(out_sat); c.c = cyc;
            q.push_back(c);
        end
        if (out_valid6 && out_ready) begin
            c.d = int'(out_data6); c.s = int'(out_sat6); c.c = cyc;
            q6.push_back(c);
        end
        if (bp) begin
            stall = out_valid && !out_ready;
            chk("bp_in_ready", int'(in_ready), int'(!stall));
            if (prev_stall) begin
                chk("bp_hold_valid", int'(out_valid), 1);
                chk("bp_hold_data", int'(out_data), prev_d);
            end
            if (stall) n_stall++;
            prev_stall = stall;
            prev_d = int'(out_data);
        end
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic send(input int d);
        in_valid = 1;
        in_data = 16'(d);
        for (int k = 0; k < 50 && !in_ready; k++) step();
        chk("send_ready", int'(in_ready), 1);
        step();
        acc_c.push_back(cyc);
    endtask

    task automatic wcoef(input int a, input int val);
        coef_we = 1;
        coef_addr = 3'(a);
        coef_wdata = 16'(val);
        step();
        coef_we = 0;
    endtask

    task automatic addv(input int din, input int dout, input int sat);
        vec_t t;
        t.din = din; t.dout = dout; t.sat = sat;
        tv.push_back(t);
    endtask

    task automatic run_tv(input string name);
        q.delete();
        acc_c.delete();
        foreach (tv[i]) send(tv[i].din);
        in_valid = 0;
        for (int k = 0; k < 60 && q.size() < tv.size(); k++) step();
        chk({name, "_count"}, q.size(), tv.size());
        foreach (tv[i])
            if (i < q.size()) begin
                chk($sformatf("%s_data[%0d]", name, i), q[i].d, tv[i].dout);
                chk($sformatf("%s_sat[%0d]", name, i), q[i].s, tv[i].sat);
                chk($sformatf("%s_lat[%0d]", name, i), q[i].c - acc_c[i], 5);
            end
        tv.delete();
    endtask

    task automatic pulse_clear();
        in_valid = 0;
        clear = 1;
        step();
        clear = 0;
    endtask

    initial begin
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_sat", int'(out_sat), 0);
        chk("rst_out_valid6", int'(out_valid6), 0);
        step();
        step();
        reset = 1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_in_ready6", int'(in_ready6), 1);
        out_ready = 1;

        addv(100, 100, 0); addv(-200, -200, 0); addv(32767, 32767, 0);
        run_tv("pass");

        pulse_clear();
        wcoef(0, 16384); wcoef(1, 8192); wcoef(2, -8192);
        addv(1000, 500, 0);
        addv(0, 250, 0); addv(0, -250, 0);
        for (int i = 0; i < 5; i++) addv(0, 0, 0);
        addv(3, 2, 0); addv(0, 1, 0); addv(0, -1, 0);
        addv(-3, -1, 0); addv(0, -1, 0); addv(0, 1, 0);
        run_tv("imp");

        pulse_clear();
        for (int k = 0; k < 8; k++) wcoef(k, 32767);
        addv(32767, 32766, 0);
        for (int i = 1; i < 10; i++) addv(32767, 32767, 1);
        for (int i = 1; i <= 3; i++) addv(-32768, 32767, 1);
        addv(-32768, -4, 0);
        for (int i = 5; i <= 10; i++) addv(-32768, -32768, 1);
        run_tv("sat");

        wcoef(0, 16384);
        for (int k = 1; k < 8; k++) wcoef(k, 0);
        q.delete();
        sent = 0;
        n_stall = 0;
        prev_stall = 0;
        bp = 1;
        for (int c = 0; c < 300 && q.size() < 12; c++) begin
            out_ready = (c % 4 == 0) || (c % 4 == 3);
            in_valid = sent < 12;
            in_data = 16'(200 * sent - 1000);
            step();
            if (acc_seen) sent++;
        end
        bp = 0;
        in_valid = 0;
        out_ready = 1;
        step();
        chk("bp_count", q.size(), 12);
        chk("bp_sent", sent, 12);
        chk("bp_stalls_seen", int'(n_stall > 0), 1);
        foreach (q[i]) chk($sformatf("bp_data[%0d]", i), q[i].d, 100 * i - 500);

        q.delete();
        for (int i = 1; i <= 5; i++) send(2 * i);
        pulse_clear();
        for (int k = 0; k < 10; k++) step();
        chk("clr_no_out", q.size(), 0);
        wcoef(1, 8192);
        addv(1000, 500, 0); addv(0, 250, 0); addv(0, 0, 0);
        run_tv("clr_imp");

        in_valid = 0;
        reset = 0;
        step();
        step();
        reset = 1;
        wcoef(7, 16384);
        wcoef(6, 16384);
        q6.delete();
        send(100); send(300); send(-50);
        in_valid = 0;
        for (int k = 0; k < 30 && q6.size() < 3; k++) step();
        chk("oor_count", q6.size(), 3);
        if (q6.size() == 3) begin
            chk("oor_data0", q6[0].d, 100);
            chk("oor_data1", q6[1].d, 300);
            chk("oor_data2", q6[2].d, -50);
        end
        wcoef(0, 16384);
        for (int i = 0; i < 6; i++) send(1000);
        in_valid = 0;
        chk("arst_pre_valid", int'(out_valid6), 1);
        reset = 0;
        #1;
        chk("arst_valid6", int'(out_valid6), 0);
        chk("arst_valid", int'(out_valid), 0);
        chk("arst_data6", int'(out_data6), 0);
        step();
        step();
        reset = 1;
        q6.delete();
        for (int k = 0; k < 8; k++) step();
        chk("arst_no_out", q6.size(), 0);
        send(100);
        in_valid = 0;
        for (int k = 0; k < 20 && q6.size() < 1; k++) step();
        chk("arst_unity_count", q6.size(), 1);
        if (q6.size() > 0) begin
            chk("arst_unity_data", q6[0].d, 100);
            chk("arst_unity_sat", q6[0].s, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
